// File: rtl/uart_rx_parity_engine.sv
// Serial parity checker for the UART receive path: accumulates parity as data bits
// arrive, checks the received parity bit, and tracks sequencing and parity errors.
module uart_rx_parity_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 par_en,
   input  logic [1:0]           par_mode,
   input  logic                 frame_start,
   input  logic                 data_bit_vld,
   input  logic                 par_bit_vld,
   input  logic                 sampled_bit,
   input  logic                 err_clr,
   output logic                 par_done,
   output logic                 par_err,
   output logic                 seq_err,
   output logic                 par_err_sticky,
   output logic [CNT_WIDTH-1:0] par_err_cnt
);

   localparam int BCW = $clog2(DATA_WIDTH + 1);
   localparam logic [BCW-1:0]       LAST_BIT = BCW'(DATA_WIDTH - 1);
   localparam logic [BCW-1:0]       BIT_ONE  = BCW'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {IDLE, ACCUM, WAIT_PAR} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [1:0]     mode_q;
   logic           acc;
   logic [BCW-1:0] bit_cnt;
   logic           load_frame;
   logic           acc_upd;
   logic           chk_fire;
   logic           seq_fire;
   logic           exp_bit;
   logic           new_err;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   // Priority: par_en drop aborts, then frame_start restarts, then per-state handling.
   // A parity pulse always wins over a same-cycle data pulse.
   always_comb begin
      state_nxt  = state;
      load_frame = 1'b0;
      acc_upd    = 1'b0;
      chk_fire   = 1'b0;
      seq_fire   = 1'b0;
      if (!par_en) begin
         state_nxt = IDLE;
      end else if (frame_start) begin
         load_frame = 1'b1;
         state_nxt  = ACCUM;
      end else begin
         case (state)
            ACCUM: begin
               if (par_bit_vld) begin
                  seq_fire  = 1'b1;
                  state_nxt = IDLE;
               end else if (data_bit_vld) begin
                  acc_upd = 1'b1;
                  if (bit_cnt == LAST_BIT) state_nxt = WAIT_PAR;
               end
            end
            WAIT_PAR: begin
               if (par_bit_vld) begin
                  chk_fire  = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      exp_bit = 1'b0;
      case (mode_q)
         2'b00:   exp_bit = acc;
         2'b01:   exp_bit = ~acc;
         2'b10:   exp_bit = 1'b1;
         default: exp_bit = 1'b0;
      endcase
      new_err = chk_fire & (exp_bit ^ sampled_bit);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         mode_q         <= 2'b00;
         acc            <= 1'b0;
         bit_cnt        <= '0;
         par_done       <= 1'b0;
         par_err        <= 1'b0;
         seq_err        <= 1'b0;
         par_err_sticky <= 1'b0;
         par_err_cnt    <= '0;
      end else begin
         par_done <= chk_fire;
         seq_err  <= seq_fire;
         if (load_frame) begin
            mode_q  <= par_mode;
            acc     <= 1'b0;
            bit_cnt <= '0;
         end else if (acc_upd) begin
            acc     <= acc ^ sampled_bit;
            bit_cnt <= bit_cnt + BIT_ONE;
         end
         if (chk_fire) par_err <= exp_bit ^ sampled_bit;
         // A new error in the same cycle as err_clr leaves one counted error.
         if (new_err)      par_err_sticky <= 1'b1;
         else if (err_clr) par_err_sticky <= 1'b0;
         if (err_clr)
            par_err_cnt <= new_err ? CNT_ONE : '0;
         else if (new_err && par_err_cnt != CNT_MAX)
            par_err_cnt <= par_err_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_uart_rx_parity_engine.sv
// Directed bench for uart_rx_parity_engine: a vector table of whole frames plus
// hand-written sequences for restart, abort, reset and counter saturation.
module tb_uart_rx_parity_engine;

   logic       CLK = 1'b0;
   logic       RST;
   logic       par_en;
   logic [1:0] par_mode;
   logic       frame_start;
   logic       data_bit_vld;
   logic       par_bit_vld;
   logic       sampled_bit;
   logic       err_clr;
   logic       par_done, par_err, seq_err, par_err_sticky;
   logic [7:0] par_err_cnt;
   logic       par_done2, par_err2, seq_err2, par_err_sticky2;
   logic [1:0] par_err_cnt2;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   uart_rx_parity_engine dut (
      .CLK(CLK), .RST(RST), .par_en(par_en), .par_mode(par_mode),
      .frame_start(frame_start), .data_bit_vld(data_bit_vld),
      .par_bit_vld(par_bit_vld), .sampled_bit(sampled_bit), .err_clr(err_clr),
      .par_done(par_done), .par_err(par_err), .seq_err(seq_err),
      .par_err_sticky(par_err_sticky), .par_err_cnt(par_err_cnt)
   );

   uart_rx_parity_engine #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut2 (
      .CLK(CLK), .RST(RST), .par_en(par_en), .par_mode(par_mode),
      .frame_start(frame_start), .data_bit_vld(data_bit_vld),
      .par_bit_vld(par_bit_vld), .sampled_bit(sampled_bit), .err_clr(err_clr),
      .par_done(par_done2), .par_err(par_err2), .seq_err(seq_err2),
      .par_err_sticky(par_err_sticky2), .par_err_cnt(par_err_cnt2)
   );

   typedef struct {
      logic [1:0] mode;
      logic [7:0] data;
      int         nbits;
      logic       pbit;
      logic       exp_done;
      logic       exp_err;
      logic       exp_seq;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // All driver tasks are entered at a falling edge and return at a falling edge.
   task automatic start_frame(input logic [1:0] mode);
      par_mode    = mode;
      frame_start = 1'b1;
      @(negedge CLK);
      frame_start = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] data, input int n);
      for (int i = 0; i < n; i++) begin
         sampled_bit  = data[i];
         data_bit_vld = 1'b1;
         @(negedge CLK);
         data_bit_vld = 1'b0;
      end
   endtask

   task automatic send_par(input logic pbit, input logic clr,
                           output logic d, output logic e, output logic s);
      sampled_bit = pbit;
      par_bit_vld = 1'b1;
      err_clr     = clr;
      @(negedge CLK);
      par_bit_vld = 1'b0;
      err_clr     = 1'b0;
      d = par_done;
      e = par_err;
      s = seq_err;
   endtask

   task automatic run_frame(input logic [1:0] mode, input logic [7:0] data, input int n,
                            input logic pbit, input logic clr,
                            output logic d, output logic e, output logic s);
      start_frame(mode);
      send_bits(data, n);
      send_par(pbit, clr, d, e, s);
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(negedge CLK);
      err_clr = 1'b0;
   endtask

   initial begin
      logic d, e, s;
      logic [7:0] exp_cnt8;
      logic [1:0] exp_cnt2;

      vecs[0] = '{2'b00, 8'hA5, 8, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      vecs[1] = '{2'b01, 8'hA5, 8, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
      vecs[2] = '{2'b10, 8'h3C, 8, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
      vecs[3] = '{2'b11, 8'h3C, 8, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
      vecs[4] = '{2'b00, 8'h01, 8, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3};
      vecs[5] = '{2'b01, 8'hFF, 8, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3};
      vecs[6] = '{2'b00, 8'h07, 5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
      vecs[7] = '{2'b11, 8'h00, 8, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4};
      vecs[8] = '{2'b00, 8'h01, 8, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4};

      RST = 1'b0; par_en = 1'b1; par_mode = 2'b00; frame_start = 1'b0;
      data_bit_vld = 1'b0; par_bit_vld = 1'b0; sampled_bit = 1'b0; err_clr = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      check("reset_outputs", {par_done, par_err, seq_err, par_err_sticky, par_err_cnt}, 32'h0);

      for (int i = 0; i < 9; i++) begin
         run_frame(vecs[i].mode, vecs[i].data, vecs[i].nbits, vecs[i].pbit, 1'b0, d, e, s);
         check($sformatf("vec%0d_done", i), d, vecs[i].exp_done);
         check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
         check($sformatf("vec%0d_seq", i), s, vecs[i].exp_seq);
         check($sformatf("vec%0d_cnt", i), par_err_cnt, vecs[i].exp_cnt);
         check($sformatf("vec%0d_sticky", i), par_err_sticky, vecs[i].exp_cnt != 8'd0);
         @(negedge CLK);
         check($sformatf("vec%0d_pulse_end", i), {par_done, seq_err}, 2'b00);
      end

      pulse_clr();
      check("clr_sticky", par_err_sticky, 1'b0);
      check("clr_cnt", par_err_cnt, 8'd0);
      check("clr_err_held", par_err, 1'b0);

      // Restart mid-frame must discard the partial accumulation.
      start_frame(2'b00);
      send_bits(8'h07, 3);
      run_frame(2'b00, 8'h00, 8, 1'b0, 1'b0, d, e, s);
      check("restart_done", d, 1'b1);
      check("restart_err", e, 1'b0);

      // par_en drop aborts; later bits and parity are ignored.
      start_frame(2'b00);
      send_bits(8'h0F, 4);
      par_en = 1'b0;
      @(negedge CLK);
      par_en = 1'b1;
      send_bits(8'h00, 4);
      send_par(1'b1, 1'b0, d, e, s);
      check("abort_no_done", d, 1'b0);
      check("abort_no_seq", s, 1'b0);
      check("abort_cnt", par_err_cnt, 8'd0);

      // Mode change mid-frame is not picked up: odd stays in force.
      start_frame(2'b01);
      send_bits(8'h05, 4);
      par_mode = 2'b00;
      send_bits(8'h0A, 4);
      send_par(1'b0, 1'b0, d, e, s);
      check("mode_latch_err", e, 1'b1);

      // Extra data bit in WAIT_PAR is ignored.
      run_frame(2'b00, 8'h00, 8, 1'b0, 1'b0, d, e, s);
      start_frame(2'b00);
      send_bits(8'h00, 8);
      send_bits(8'h01, 1);
      send_par(1'b0, 1'b0, d, e, s);
      check("waitpar_ignore_done", d, 1'b1);
      check("waitpar_ignore_err", e, 1'b0);

      // Saturation: 8-bit counter keeps counting, 2-bit counter stops at 3.
      pulse_clr();
      check("sat_clr_cnt2", par_err_cnt2, 2'd0);
      exp_cnt8 = 8'd0;
      exp_cnt2 = 2'd0;
      for (int k = 1; k <= 5; k++) begin
         run_frame(2'b10, 8'h00, 8, 1'b0, 1'b0, d, e, s);
         exp_cnt8 = exp_cnt8 + 8'd1;
         if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
         check($sformatf("sat%0d_err", k), e, 1'b1);
         check($sformatf("sat%0d_cnt8", k), par_err_cnt, exp_cnt8);
         check($sformatf("sat%0d_cnt2", k), par_err_cnt2, exp_cnt2);
      end

      run_frame(2'b10, 8'h00, 8, 1'b0, 1'b1, d, e, s);
      check("clr_vs_err_cnt8", par_err_cnt, 8'd1);
      check("clr_vs_err_cnt2", par_err_cnt2, 2'd1);
      check("clr_vs_err_sticky", par_err_sticky, 1'b1);

      // Asynchronous reset mid-frame, then a clean frame.
      start_frame(2'b00);
      send_bits(8'h07, 3);
      RST = 1'b0;
      #1;
      check("rst_mid_outputs", {par_done, par_err, seq_err, par_err_sticky, par_err_cnt}, 32'h0);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      run_frame(2'b00, 8'h01, 8, 1'b1, 1'b0, d, e, s);
      check("post_rst_done", d, 1'b1);
      check("post_rst_err", e, 1'b0);
      check("post_rst_cnt", par_err_cnt, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
